// File: rtl/debug_uart_if.sv
// Debugger-to-reporter bundle: the debug-word triplet and trigger controls in,
// the serial line and frame status out.
interface debug_uart_if;
  logic [31:0] debug_1_i;
  logic [31:0] debug_2_i;
  logic [31:0] debug_3_i;
  logic        trig_i;
  logic        drop_clr_i;
  logic        uart_tx_o;
  logic        busy_o;
  logic        done_o;
  logic        trig_drop_o;

  modport master (
    output debug_1_i, debug_2_i, debug_3_i, trig_i, drop_clr_i,
    input  uart_tx_o, busy_o, done_o, trig_drop_o
  );

  modport slave (
    input  debug_1_i, debug_2_i, debug_3_i, trig_i, drop_clr_i,
    output uart_tx_o, busy_o, done_o, trig_drop_o
  );
endinterface

// File: rtl/debug_uart_reporter.sv
// Snapshots the three debug words on a trigger and sends them as a 14-byte 8N1 frame:
// SYNC, twelve data bytes (MSB byte of debug_1 first), XOR checksum of the data bytes.
module debug_uart_reporter #(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic         clk,
  input  logic         rst_n,
  debug_uart_if.slave  bus
);

  localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     LAST_BYTE = 4'd13;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [3:0]    r_byte_idx;
  logic          r_tx;
  logic          r_busy;
  logic          r_done;
  logic          r_drop;

  logic [95:0]   r_snap;
  logic [7:0]    r_shift;
  logic [7:0]    r_chk;

  logic          w_accept;
  logic          w_bit_end;
  logic [3:0]    w_next_idx;
  logic [7:0]    w_next_byte;

  // Data byte idx (1..12) of the snapshot; idx 1 is debug_1[31:24].
  function automatic logic [7:0] snap_byte(input logic [95:0] s, input logic [3:0] idx);
    return 8'(s >> (8 * (12 - int'(idx))));
  endfunction

  assign w_accept    = (r_state == S_IDLE) && bus.trig_i;
  assign w_bit_end   = (r_cnt == LAST_CNT);
  assign w_next_idx  = r_byte_idx + 4'd1;
  assign w_next_byte = snap_byte(r_snap, w_next_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_byte_idx <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // A drop in the same cycle as a clear must win.
      if (r_busy && bus.trig_i)
        r_drop <= 1'b1;
      else if (bus.drop_clr_i)
        r_drop <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.trig_i) begin
            r_state    <= S_START;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_byte_idx <= '0;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit <= r_bit + 3'd1;
              r_tx  <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_byte_idx == LAST_BYTE) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_tx    <= 1'b1;
            end else begin
              r_byte_idx <= w_next_idx;
              r_state    <= S_START;
              r_tx       <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // Payload path: loaded on acceptance and at each byte boundary, no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_snap  <= {bus.debug_1_i, bus.debug_2_i, bus.debug_3_i};
      r_shift <= SYNC_BYTE;
      r_chk   <= 8'h00;
    end else if (r_state == S_DATA && w_bit_end && r_bit != 3'd7) begin
      r_shift <= r_shift >> 1;
    end else if (r_state == S_STOP && w_bit_end && r_byte_idx != LAST_BYTE) begin
      if (w_next_idx == LAST_BYTE) begin
        r_shift <= r_chk;
      end else begin
        r_shift <= w_next_byte;
        r_chk   <= r_chk ^ w_next_byte;
      end
    end
  end

  assign bus.uart_tx_o   = r_tx;
  assign bus.busy_o      = r_busy;
  assign bus.done_o      = r_done;
  assign bus.trig_drop_o = r_drop;

endmodule
